// File: rtl/eth_motor_pkg.sv
// Shared definitions for the motor command receive path.
// Downstream decoders use these to interpret CMD_CODE.
package eth_motor_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CODE  = 3'd1;
    localparam state_t S_LEN   = 3'd2;
    localparam state_t S_ARG   = 3'd3;
    localparam state_t S_CSUM  = 3'd4;
    localparam state_t S_DRAIN = 3'd5;
    localparam state_t S_HOLD  = 3'd6;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    localparam logic [7:0] CMD_MOVE = 8'h01;
    localparam logic [7:0] CMD_STOP = 8'h02;
    localparam logic [7:0] CMD_HOME = 8'h03;

endpackage

// File: rtl/eth_motor_cmd_rx.sv
// Parses HDR/CODE/LEN/payload/CSUM frames from the UDP payload stream
// into a held command word; rejected frames pulse CMD_ERR and are counted.
module eth_motor_cmd_rx
    import eth_motor_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN  = 8,
    parameter int unsigned ERRCNT_W = 16
) (
    input  logic                CLK_125M,
    input  logic                SYS_RST,
    input  logic                ETH_MOTOR_TVALID,
    output logic                ETH_MOTOR_TREADY,
    input  logic [7:0]          ETH_MOTOR_TDATA,
    input  logic                ETH_MOTOR_TLAST,
    output logic                CMD_VALID,
    input  logic                CMD_READY,
    output logic [7:0]          CMD_CODE,
    output logic [7:0]          CMD_LEN,
    output logic [31:0]         CMD_ARG,
    output logic                CMD_ERR,
    output logic [ERRCNT_W-1:0] ERR_CNT
);

    localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

    state_t      state, state_n;
    logic        take, err;
    logic [7:0]  xor_r, code_r, len_r, idx;
    logic [31:0] arg_r;

    assign ETH_MOTOR_TREADY = (state != S_HOLD);
    assign CMD_VALID        = (state == S_HOLD);
    assign take             = ETH_MOTOR_TVALID && ETH_MOTOR_TREADY;

    always_comb begin
        state_n = state;
        err     = 1'b0;
        if (state == S_HOLD) begin
            if (CMD_READY) state_n = S_IDLE;
        end else if (take) begin
            case (state)
                S_IDLE: begin
                    if (ETH_MOTOR_TDATA == HDR_BYTE && !ETH_MOTOR_TLAST) begin
                        state_n = S_CODE;
                    end else begin
                        err     = 1'b1;
                        state_n = ETH_MOTOR_TLAST ? S_IDLE : S_DRAIN;
                    end
                end
                S_CODE: begin
                    if (ETH_MOTOR_TLAST) begin
                        err     = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_LEN;
                    end
                end
                S_LEN: begin
                    if (ETH_MOTOR_TLAST) begin
                        err     = 1'b1;
                        state_n = S_IDLE;
                    end else if (ETH_MOTOR_TDATA > MAX_LEN_B) begin
                        err     = 1'b1;
                        state_n = S_DRAIN;
                    end else begin
                        state_n = (ETH_MOTOR_TDATA != 8'd0) ? S_ARG : S_CSUM;
                    end
                end
                S_ARG: begin
                    // TLAST on any payload byte leaves no room for CSUM
                    if (ETH_MOTOR_TLAST) begin
                        err     = 1'b1;
                        state_n = S_IDLE;
                    end else if (idx == len_r - 8'd1) begin
                        state_n = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (ETH_MOTOR_TDATA == xor_r && ETH_MOTOR_TLAST) begin
                        state_n = S_HOLD;
                    end else begin
                        err     = 1'b1;
                        state_n = ETH_MOTOR_TLAST ? S_IDLE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ETH_MOTOR_TLAST) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_125M or posedge SYS_RST) begin
        if (SYS_RST) begin
            state    <= S_IDLE;
            xor_r    <= '0;
            code_r   <= '0;
            len_r    <= '0;
            idx      <= '0;
            arg_r    <= '0;
            CMD_CODE <= '0;
            CMD_LEN  <= '0;
            CMD_ARG  <= '0;
            CMD_ERR  <= 1'b0;
            ERR_CNT  <= '0;
        end else begin
            state   <= state_n;
            CMD_ERR <= err;
            if (err && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
            if (take) begin
                case (state)
                    S_CODE: begin
                        code_r <= ETH_MOTOR_TDATA;
                        xor_r  <= ETH_MOTOR_TDATA;
                    end
                    S_LEN: begin
                        len_r <= ETH_MOTOR_TDATA;
                        xor_r <= xor_r ^ ETH_MOTOR_TDATA;
                        arg_r <= '0;
                        idx   <= '0;
                    end
                    S_ARG: begin
                        xor_r <= xor_r ^ ETH_MOTOR_TDATA;
                        idx   <= idx + 8'd1;
                        // Left-justified: payload byte 0 lands in [31:24]
                        case (idx)
                            8'd0:    arg_r[31:24] <= ETH_MOTOR_TDATA;
                            8'd1:    arg_r[23:16] <= ETH_MOTOR_TDATA;
                            8'd2:    arg_r[15:8]  <= ETH_MOTOR_TDATA;
                            8'd3:    arg_r[7:0]   <= ETH_MOTOR_TDATA;
                            default: ;
                        endcase
                    end
                    S_CSUM: begin
                        if (state_n == S_HOLD) begin
                            CMD_CODE <= code_r;
                            CMD_LEN  <= len_r;
                            CMD_ARG  <= arg_r;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_motor_cmd_rx.sv
// Directed-vector bench for eth_motor_cmd_rx with hand-computed expectations.
module tb_eth_motor_cmd_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [7:0]  tdata = 8'h00;
    logic        tlast = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_code, cmd_len;
    logic [31:0] cmd_arg;
    logic        cmd_err;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [7:0]  fq[$];

    eth_motor_cmd_rx #(.HDR_BYTE(8'hA5), .MAX_LEN(8), .ERRCNT_W(16)) dut (
        .CLK_125M(clk), .SYS_RST(rst),
        .ETH_MOTOR_TVALID(tvalid), .ETH_MOTOR_TREADY(tready),
        .ETH_MOTOR_TDATA(tdata), .ETH_MOTOR_TLAST(tlast),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_CODE(cmd_code), .CMD_LEN(cmd_len), .CMD_ARG(cmd_arg),
        .CMD_ERR(cmd_err), .ERR_CNT(err_cnt)
    );

    always #4 clk = ~clk;

    // Returns 1 ns after the edge on which the byte transferred.
    task automatic send(input logic [7:0] d, input logic l);
        int unsigned n = 0;
        @(negedge clk);
        tvalid = 1'b1; tdata = d; tlast = l;
        while (!tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout: tready=%b after %0d cycles, required 1", tready, n);
        end
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_q();
        for (int i = 0; i < fq.size(); i++) send(fq[i], i == fq.size() - 1);
    endtask

    task automatic accept();
        @(negedge clk); cmd_ready = 1'b1;
        @(posedge clk); #1; cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL accept_valid_drop: got %b required 0", cmd_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_valid, cmd_code, cmd_len, cmd_arg, cmd_err, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b c=%h l=%h a=%h e=%b n=%0d required all 0",
                     cmd_valid, cmd_code, cmd_len, cmd_arg, cmd_err, err_cnt);
        end
        @(negedge clk); rst = 1'b0;
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b required 1", tready); end
    endtask

    task automatic test_good_frame();
        fq = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
        send_q();
        checks++;
        if ({cmd_valid, cmd_code, cmd_len, cmd_arg, cmd_err} !== {1'b1, 8'h01, 8'h04, 32'h11223344, 1'b0}) begin
            errors++;
            $display("FAIL good_cmd: got v=%b c=%h l=%h a=%h e=%b required v=1 c=01 l=04 a=11223344 e=0",
                     cmd_valid, cmd_code, cmd_len, cmd_arg, cmd_err);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tready !== 1'b0 || cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL good_hold: got tready=%b valid=%b required 0/1", tready, cmd_valid);
        end
        accept();
    endtask

    task automatic test_short_payload();
        fq = '{8'hA5, 8'h02, 8'h02, 8'hAB, 8'hCD, 8'h66};
        send_q();
        checks++;
        if ({cmd_valid, cmd_code, cmd_len, cmd_arg} !== {1'b1, 8'h02, 8'h02, 32'hABCD0000}) begin
            errors++;
            $display("FAIL short_cmd: got v=%b c=%h l=%h a=%h required v=1 c=02 l=02 a=abcd0000",
                     cmd_valid, cmd_code, cmd_len, cmd_arg);
        end
        accept();
        fq = '{8'hA5, 8'h03, 8'h00, 8'h03};
        send_q();
        checks++;
        if ({cmd_valid, cmd_code, cmd_len, cmd_arg} !== {1'b1, 8'h03, 8'h00, 32'h0}) begin
            errors++;
            $display("FAIL zero_len_cmd: got v=%b c=%h l=%h a=%h required v=1 c=03 l=00 a=0",
                     cmd_valid, cmd_code, cmd_len, cmd_arg);
        end
        accept();
    endtask

    task automatic test_bad_checksum();
        fq = '{8'hA5, 8'h01, 8'h01, 8'h10, 8'hFF};
        send_q();
        exp_cnt++;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_err !== 1'b1 || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL bad_csum: got v=%b e=%b n=%0d required v=0 e=1 n=%0d", cmd_valid, cmd_err, err_cnt, exp_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (cmd_err !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum_pulse: got e=%b v=%b required 0/0", cmd_err, cmd_valid);
        end
    endtask

    task automatic test_bad_header();
        send(8'h5A, 1'b0);
        exp_cnt++;
        checks++;
        if (cmd_err !== 1'b1 || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL bad_hdr_err: got e=%b n=%0d required 1/%0d", cmd_err, err_cnt, exp_cnt);
        end
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        checks++;
        if (cmd_err !== 1'b0 || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL bad_hdr_drain: got e=%b n=%0d required 0/%0d", cmd_err, err_cnt, exp_cnt);
        end
        fq = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
        send_q();
        checks++;
        if ({cmd_valid, cmd_code, cmd_arg} !== {1'b1, 8'h01, 32'h11223344} || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL bad_hdr_recover: got v=%b c=%h a=%h n=%0d required v=1 c=01 a=11223344 n=%0d",
                     cmd_valid, cmd_code, cmd_arg, err_cnt, exp_cnt);
        end
        accept();
    endtask

    task automatic test_len_and_early_last();
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        send(8'h09, 1'b0);
        exp_cnt++;
        checks++;
        if (cmd_err !== 1'b1 || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL len_over_err: got e=%b n=%0d required 1/%0d", cmd_err, err_cnt, exp_cnt);
        end
        for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
        send(8'hEE, 1'b1);
        checks++;
        if (cmd_err !== 1'b0 || err_cnt !== exp_cnt || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL len_over_drain: got e=%b n=%0d v=%b required 0/%0d/0", cmd_err, err_cnt, cmd_valid, exp_cnt);
        end
        fq = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22};
        send_q();
        exp_cnt++;
        checks++;
        if (cmd_err !== 1'b1 || err_cnt !== exp_cnt || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_last: got e=%b n=%0d v=%b required 1/%0d/0", cmd_err, err_cnt, cmd_valid, exp_cnt);
        end
        fq = '{8'hA5, 8'h03, 8'h00, 8'h03};
        send_q();
        checks++;
        if ({cmd_valid, cmd_code, cmd_len} !== {1'b1, 8'h03, 8'h00} || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL early_last_recover: got v=%b c=%h l=%h n=%0d required v=1 c=03 l=00 n=%0d",
                     cmd_valid, cmd_code, cmd_len, err_cnt, exp_cnt);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        fq = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
        send_q();
        @(negedge clk);
        tvalid = 1'b1; tdata = 8'hA5; tlast = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tready !== 1'b0 || cmd_valid !== 1'b1 || cmd_code !== 8'h01 || cmd_arg !== 32'h11223344) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles, required 0", bad);
        end
        accept();
        send(8'hA5, 1'b0);
        fq = '{8'h02, 8'h02, 8'hAB, 8'hCD, 8'h66};
        send_q();
        checks++;
        if ({cmd_valid, cmd_code, cmd_len, cmd_arg} !== {1'b1, 8'h02, 8'h02, 32'hABCD0000} || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL second_cmd: got v=%b c=%h l=%h a=%h n=%0d required v=1 c=02 l=02 a=abcd0000 n=%0d",
                     cmd_valid, cmd_code, cmd_len, cmd_arg, err_cnt, exp_cnt);
        end
        accept();
    endtask

    task automatic test_reset_mid_frame();
        fq = '{8'hA5, 8'h01, 8'h04, 8'h11};
        for (int i = 0; i < fq.size(); i++) send(fq[i], 1'b0);
        @(negedge clk); rst = 1'b1;
        #1;
        checks++;
        if ({cmd_valid, cmd_code, cmd_len, cmd_arg, cmd_err, err_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v=%b c=%h l=%h a=%h e=%b n=%0d required all 0",
                     cmd_valid, cmd_code, cmd_len, cmd_arg, cmd_err, err_cnt);
        end
        @(negedge clk); rst = 1'b0;
        exp_cnt = 16'd1;
        send(8'h22, 1'b0);
        checks++;
        if (cmd_err !== 1'b1 || err_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL mid_reset_tail_err: got e=%b n=%0d required 1/%0d", cmd_err, err_cnt, exp_cnt);
        end
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h41, 1'b1);
        checks++;
        if (cmd_err !== 1'b0 || err_cnt !== exp_cnt || cmd_valid !== 1'b0 || tready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_tail_drain: got e=%b n=%0d v=%b r=%b required 0/%0d/0/1",
                     cmd_err, err_cnt, cmd_valid, tready, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_payload();
        test_bad_checksum();
        test_bad_header();
        test_len_and_early_last();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_motor_cmd_rx.md
Name: eth_motor_cmd_rx

Overview:
- Downstream consumer of the received-UDP-payload AXIS byte stream (ETH_MOTOR_T* leaving the RX FIFO); parses motor command frames into a registered command word for the motor controller.
- Validates header, length and XOR checksum; delivers one command per good frame via a valid/ready handshake; flags and counts bad frames.
- Back-pressures the FIFO while a parsed command waits to be taken.

Parameters:
- HDR_BYTE, 8'hA5, required first byte of every frame
- MAX_LEN, 8, maximum payload length in bytes (1..255)
- ERRCNT_W, 16, width of the bad-frame counter

Ports:
- CLK_125M  in  1  system clock
- SYS_RST  in  1  reset, asynchronous, active-high
- ETH_MOTOR_TVALID  in  1  input stream byte valid
- ETH_MOTOR_TREADY  out  1  input stream ready
- ETH_MOTOR_TDATA  in  8  input stream byte
- ETH_MOTOR_TLAST  in  1  last byte of UDP payload
- CMD_VALID  out  1  parsed command available
- CMD_READY  in  1  consumer accepts command
- CMD_CODE  out  8  command byte
- CMD_LEN  out  8  payload length of the command
- CMD_ARG  out  32  first 4 payload bytes, big-endian; missing bytes zero
- CMD_ERR  out  1  one-cycle pulse on each rejected frame
- ERR_CNT  out  ERRCNT_W  saturating rejected-frame count

Behaviour:
- Frame: HDR, CODE, LEN, LEN payload bytes, CSUM, where CSUM = XOR of CODE, LEN and all payload bytes. TLAST is required on the CSUM byte.
- A byte transfers when TVALID && TREADY. TREADY = 1 in every state except HOLD.
- Reset values: all outputs 0; FSM in IDLE; CMD_ARG/CODE/LEN 0; ERR_CNT 0.
- FSM states and transitions, evaluated per accepted byte:
  - IDLE: byte == HDR_BYTE and !TLAST -> CODE. Any other byte -> error; go to DRAIN, or stay in IDLE if TLAST.
  - CODE: store byte, init running xor = byte -> LEN. TLAST -> error, IDLE.
  - LEN: LEN > MAX_LEN -> error; go to DRAIN, or IDLE if TLAST. Otherwise store LEN, xor ^= byte, clear CMD_ARG, then go to ARG if LEN > 0, else CSUM. TLAST here -> error, IDLE.
  - ARG: xor ^= byte. Payload index i < 4 shifts the byte into CMD_ARG (byte 0 ends in [31:24], left-justified: arg bytes fill MSB-first). Leave for CSUM after LEN bytes. TLAST before the last payload byte -> error, IDLE.
  - CSUM: byte == xor and TLAST -> HOLD. Byte == xor and !TLAST -> error, DRAIN. Byte != xor -> error; go to IDLE if TLAST, else DRAIN.
  - DRAIN: discard bytes until an accepted TLAST -> IDLE.
  - HOLD: CMD_VALID = 1; outputs stable. CMD_READY -> CMD_VALID falls next cycle -> IDLE.
- Latency: CMD_VALID rises the cycle after the CSUM byte is accepted.
- CMD_ERR: registered, asserted exactly one cycle after the offending byte. ERR_CNT increments in the same cycle and saturates at all-ones.
- Only the first error of a frame counts; DRAIN bytes do not add errors.
- TVALID gaps: state held, no timeout.
- Reset mid-frame: immediate return to IDLE with all outputs zero. The remainder of a partial frame is then parsed from IDLE, so it produces one error and drains to TLAST.
- CMD_READY asserted outside HOLD is ignored.

Decomposition:
- Shared package eth_motor_pkg holds:
  - FSM state enum (IDLE, CODE, LEN, ARG, CSUM, DRAIN, HOLD)
  - HDR_BYTE default
  - command code constants (e.g. 8'h01 MOVE, 8'h02 STOP, 8'h03 HOME) for downstream decoders
- No sub-module; a single FSM with datapath registers.

Test Plan:
- Good frame A5 01 04 11 22 33 44 CS=01^04^11^22^33^44=0x41, TLAST on 41 -> CMD_VALID next cycle; CODE=01, LEN=04, ARG=32'h11223344; CMD_ERR=0; TREADY=0 until CMD_READY.
- Short payload A5 02 02 AB CD CS=02^02^AB^CD=0x66 with TLAST -> ARG=32'hABCD0000, LEN=02; zero-length A5 03 00 03 -> ARG=0.
- Bad checksum A5 01 01 10 FF(TLAST) -> no CMD_VALID; CMD_ERR pulse one cycle later; ERR_CNT=1.
- Bad header 5A 00 00 00(TLAST) then a good frame -> one CMD_ERR; the good frame is delivered; ERR_CNT=1.
- LEN=09 with MAX_LEN=8, followed by 10 bytes then TLAST -> one error, drain, then IDLE. Early TLAST on the 2nd of 4 payload bytes -> error, IDLE.
- Back-pressure: CMD_READY held 0 for 20 cycles while the next frame is presented -> TREADY=0 throughout and outputs stable. Then pulse CMD_READY -> second command delivered intact. Assert SYS_RST mid-frame -> all outputs 0 immediately.
